// File: rtl/axi_mem_pkg.sv
// axi_mem_pkg: AXI response codes, supported beat size and FSM state types
// shared by the on-chip memory responder.
package axi_mem_pkg;
    localparam logic [1:0] RESP_OKAY      = 2'b00;
    localparam logic [1:0] RESP_SLVERR    = 2'b10;
    localparam logic [2:0] SUPPORTED_SIZE = 3'd3;

    typedef enum logic {R_IDLE, R_BURST} r_state_e;
    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;
endpackage

// File: rtl/sdp_bram.sv
// sdp_bram: simple dual-port RAM with byte write enables and a registered,
// read-first read port that holds its output while re_i is low.
module sdp_bram #(
    parameter int DATA_W = 64,
    parameter int DEPTH  = 4096,
    localparam int AW    = $clog2(DEPTH),
    localparam int NB    = DATA_W / 8
) (
    input  logic              clk,
    input  logic [NB-1:0]     we_i,
    input  logic [AW-1:0]     waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic              re_i,
    input  logic [AW-1:0]     raddr_i,
    output logic [DATA_W-1:0] rdata_o
);
    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        for (int b = 0; b < NB; b++)
            if (we_i[b]) mem[waddr_i][b*8 +: 8] <= wdata_i[b*8 +: 8];
        if (re_i) rdata_o <= mem[raddr_i];
    end
endmodule

// File: rtl/axi4_mem_responder.sv
// axi4_mem_responder: AXI4 slave answering INCR bursts from on-chip RAM,
// with independent read and write state machines.
module axi4_mem_responder
    import axi_mem_pkg::*;
#(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 64,
    parameter int ID_W      = 6,
    parameter int MEM_WORDS = 4096
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                io_ar_valid,
    output logic                io_ar_ready,
    input  logic [ADDR_W-1:0]   io_ar_bits_addr,
    input  logic [ID_W-1:0]     io_ar_bits_id,
    input  logic [7:0]          io_ar_bits_len,
    input  logic [2:0]          io_ar_bits_size,
    input  logic                io_aw_valid,
    output logic                io_aw_ready,
    input  logic [ADDR_W-1:0]   io_aw_bits_addr,
    input  logic [ID_W-1:0]     io_aw_bits_id,
    input  logic [7:0]          io_aw_bits_len,
    input  logic [2:0]          io_aw_bits_size,
    input  logic                io_w_valid,
    output logic                io_w_ready,
    input  logic [DATA_W-1:0]   io_w_bits_data,
    input  logic [DATA_W/8-1:0] io_w_bits_strb,
    input  logic                io_w_bits_last,
    output logic                io_b_valid,
    input  logic                io_b_ready,
    output logic [ID_W-1:0]     io_b_bits_id,
    output logic [1:0]          io_b_bits_resp,
    output logic                io_r_valid,
    input  logic                io_r_ready,
    output logic [DATA_W-1:0]   io_r_bits_data,
    output logic [ID_W-1:0]     io_r_bits_id,
    output logic                io_r_bits_last,
    output logic [1:0]          io_r_bits_resp
);
    localparam int IW = $clog2(MEM_WORDS);
    localparam int NB = DATA_W / 8;

    r_state_e        r_state_q, r_state_d;
    logic            ar_ready_q, ar_ready_d, go_q, go_d;
    logic [IW-1:0]   r_idx_q, r_idx_d;
    logic [8:0]      r_left_q, r_left_d;
    logic [ID_W-1:0] r_id_q, r_id_d;
    logic            r_err_q, r_err_d, r_valid_q, r_valid_d, r_last_q, r_last_d;
    logic [1:0]      r_resp_q, r_resp_d;
    logic            ar_fire, r_fire, fetch;
    logic [DATA_W-1:0] rdata;

    w_state_e        w_state_q, w_state_d;
    logic            aw_ready_q, aw_ready_d;
    logic [IW-1:0]   w_idx_q, w_idx_d;
    logic [7:0]      w_len_q, w_len_d, w_cnt_q, w_cnt_d;
    logic [ID_W-1:0] b_id_q, b_id_d;
    logic            w_err_q, w_err_d, w_bad_q, w_bad_d;
    logic [1:0]      b_resp_q, b_resp_d;
    logic            aw_fire, w_fire, w_final;
    logic [NB-1:0]   we;

    logic unused_addr;
    assign unused_addr = ^{io_ar_bits_addr[2:0], io_ar_bits_addr[ADDR_W-1:IW+3],
                           io_aw_bits_addr[2:0], io_aw_bits_addr[ADDR_W-1:IW+3]};

    // go_q delays the first fetch one cycle so the first beat lands two edges after AR
    always_comb begin
        ar_fire   = ar_ready_q && io_ar_valid;
        r_fire    = r_valid_q && io_r_ready;
        fetch     = r_state_q == R_BURST && go_q && r_left_q != 9'd0 && (!r_valid_q || io_r_ready);
        r_state_d = r_state_q;
        r_idx_d   = r_idx_q;
        r_left_d  = r_left_q;
        r_id_d    = r_id_q;
        r_err_d   = r_err_q;
        r_last_d  = r_last_q;
        r_resp_d  = r_resp_q;
        if (ar_fire) begin
            r_state_d = R_BURST;
            r_idx_d   = io_ar_bits_addr[IW+2:3];
            r_left_d  = {1'b0, io_ar_bits_len} + 9'd1;
            r_id_d    = io_ar_bits_id;
            r_err_d   = io_ar_bits_size != SUPPORTED_SIZE;
        end
        if (fetch) begin
            r_idx_d  = r_idx_q + 1'b1;
            r_left_d = r_left_q - 9'd1;
            r_last_d = r_left_q == 9'd1;
            r_resp_d = r_err_q ? RESP_SLVERR : RESP_OKAY;
        end
        if (r_fire && r_last_q) r_state_d = R_IDLE;
        r_valid_d  = fetch || (r_valid_q && !io_r_ready);
        go_d       = r_state_q == R_BURST && r_state_d == R_BURST;
        ar_ready_d = r_state_d == R_IDLE;
    end

    always_comb begin
        aw_fire   = aw_ready_q && io_aw_valid;
        w_fire    = w_state_q == W_DATA && io_w_valid;
        w_final   = w_cnt_q == w_len_q;
        we        = (w_fire && !w_err_q) ? io_w_bits_strb : '0;
        w_state_d = w_state_q;
        w_idx_d   = w_idx_q;
        w_len_d   = w_len_q;
        w_cnt_d   = w_cnt_q;
        b_id_d    = b_id_q;
        w_err_d   = w_err_q;
        w_bad_d   = w_bad_q;
        b_resp_d  = b_resp_q;
        if (aw_fire) begin
            w_state_d = W_DATA;
            w_idx_d   = io_aw_bits_addr[IW+2:3];
            w_len_d   = io_aw_bits_len;
            w_cnt_d   = 8'd0;
            b_id_d    = io_aw_bits_id;
            w_err_d   = io_aw_bits_size != SUPPORTED_SIZE;
            w_bad_d   = 1'b0;
        end
        if (w_fire) begin
            w_idx_d = w_idx_q + 1'b1;
            w_cnt_d = w_cnt_q + 8'd1;
            w_bad_d = w_bad_q || (io_w_bits_last != w_final);
            if (w_final) begin
                w_state_d = W_RESP;
                b_resp_d  = (w_err_q || w_bad_d) ? RESP_SLVERR : RESP_OKAY;
            end
        end
        if (w_state_q == W_RESP && io_b_ready) w_state_d = W_IDLE;
        aw_ready_d = w_state_d == W_IDLE;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state_q  <= R_IDLE;
            ar_ready_q <= 1'b0;
            go_q       <= 1'b0;
            r_idx_q    <= '0;
            r_left_q   <= '0;
            r_id_q     <= '0;
            r_err_q    <= 1'b0;
            r_valid_q  <= 1'b0;
            r_last_q   <= 1'b0;
            r_resp_q   <= RESP_OKAY;
            w_state_q  <= W_IDLE;
            aw_ready_q <= 1'b0;
            w_idx_q    <= '0;
            w_len_q    <= '0;
            w_cnt_q    <= '0;
            b_id_q     <= '0;
            w_err_q    <= 1'b0;
            w_bad_q    <= 1'b0;
            b_resp_q   <= RESP_OKAY;
        end else begin
            r_state_q  <= r_state_d;
            ar_ready_q <= ar_ready_d;
            go_q       <= go_d;
            r_idx_q    <= r_idx_d;
            r_left_q   <= r_left_d;
            r_id_q     <= r_id_d;
            r_err_q    <= r_err_d;
            r_valid_q  <= r_valid_d;
            r_last_q   <= r_last_d;
            r_resp_q   <= r_resp_d;
            w_state_q  <= w_state_d;
            aw_ready_q <= aw_ready_d;
            w_idx_q    <= w_idx_d;
            w_len_q    <= w_len_d;
            w_cnt_q    <= w_cnt_d;
            b_id_q     <= b_id_d;
            w_err_q    <= w_err_d;
            w_bad_q    <= w_bad_d;
            b_resp_q   <= b_resp_d;
        end
    end

    sdp_bram #(.DATA_W(DATA_W), .DEPTH(MEM_WORDS)) u_ram (
        .clk     (clk),
        .we_i    (we),
        .waddr_i (w_idx_q),
        .wdata_i (io_w_bits_data),
        .re_i    (fetch),
        .raddr_i (r_idx_q),
        .rdata_o (rdata)
    );

    assign io_ar_ready    = ar_ready_q;
    assign io_r_valid     = r_valid_q;
    assign io_r_bits_data = (r_valid_q && r_resp_q == RESP_OKAY) ? rdata : '0;
    assign io_r_bits_id   = r_id_q;
    assign io_r_bits_last = r_last_q;
    assign io_r_bits_resp = r_resp_q;
    assign io_aw_ready    = aw_ready_q;
    assign io_w_ready     = w_state_q == W_DATA;
    assign io_b_valid     = w_state_q == W_RESP;
    assign io_b_bits_id   = b_id_q;
    assign io_b_bits_resp = b_resp_q;
endmodule
